// File: rtl/gate_switch_pkg.sv
// Shared types and sizes for the gate/switch-level full-adder equivalence fixture.
package gate_switch_pkg;

  localparam int N_SUM_VARIANTS   = 5;
  localparam int N_CARRY_VARIANTS = 3;

  // sum[0..3] = xor, sop, nand, nor; sum[4] = switch-level
  // carry[0..2] = and/or, half-adder reuse, switch-level
  typedef struct packed {
    logic [N_SUM_VARIANTS-1:0]   sum;
    logic [N_CARRY_VARIANTS-1:0] carry;
  } fa_result_t;

  function automatic logic sum_disagree(input logic [N_SUM_VARIANTS-1:0] v);
    return !((&v) || !(|v));
  endfunction

  function automatic logic carry_disagree(input logic [N_CARRY_VARIANTS-1:0] v);
    return !((&v) || !(|v));
  endfunction

endpackage

// File: rtl/tg_mux2.sv
// Transmission-gate 2:1 mux model: y follows d1 when sel is high, d0 otherwise.
module tg_mux2 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/gate_switch_adder.sv
// Registered full adder built from several independent gate/switch netlists,
// with a registered flag raised whenever the implementations disagree.
module gate_switch_adder
  import gate_switch_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y0,
  output logic y0_2,
  output logic y0_3,
  output logic y0_4,
  output logic y1,
  output logic y1_2,
  output logic y0_s,
  output logic y1_s,
  output logic mismatch
);

  // Sum variant 1: cascaded XOR; ab_x is also the half-adder term for carry variant 2
  (* keep = "true" *) wire ab_x, s1_out;
  xor g_x1 (ab_x, a, b);
  xor g_x2 (s1_out, ab_x, c);

  // Sum variant 2: odd-parity minterms
  (* keep = "true" *) wire sp_na, sp_nb, sp_nc, sp_m1, sp_m2, sp_m3, sp_m4, s2_out;
  not g_sp_na (sp_na, a);
  not g_sp_nb (sp_nb, b);
  not g_sp_nc (sp_nc, c);
  and g_sp_m1 (sp_m1, sp_na, sp_nb, c);
  and g_sp_m2 (sp_m2, sp_na, b, sp_nc);
  and g_sp_m3 (sp_m3, a, sp_nb, sp_nc);
  and g_sp_m4 (sp_m4, a, b, c);
  or  g_sp_or (s2_out, sp_m1, sp_m2, sp_m3, sp_m4);

  // Sum variant 3: two four-NAND XOR cells
  (* keep = "true" *) wire n_ab, n_a, n_b, x_ab, n_xc, n_x, n_c, s3_out;
  nand g_n1 (n_ab, a, b);
  nand g_n2 (n_a, a, n_ab);
  nand g_n3 (n_b, b, n_ab);
  nand g_n4 (x_ab, n_a, n_b);
  nand g_n5 (n_xc, x_ab, c);
  nand g_n6 (n_x, x_ab, n_xc);
  nand g_n7 (n_c, c, n_xc);
  nand g_n8 (s3_out, n_x, n_c);

  // Sum variant 4: two four-NOR XNOR cells; xnor(xnor(a,b),c) equals a^b^c
  (* keep = "true" *) wire r_ab, r_a, r_b, xn_ab, r_xc, r_x, r_c, s4_out;
  nor g_r1 (r_ab, a, b);
  nor g_r2 (r_a, a, r_ab);
  nor g_r3 (r_b, b, r_ab);
  nor g_r4 (xn_ab, r_a, r_b);
  nor g_r5 (r_xc, xn_ab, c);
  nor g_r6 (r_x, xn_ab, r_xc);
  nor g_r7 (r_c, c, r_xc);
  nor g_r8 (s4_out, r_x, r_c);

  // Carry variants 1 and 2
  (* keep = "true" *) wire c_ab, c_ac, c_bc, c1_out, k_ab, k_xc, c2_out;
  and g_c_ab (c_ab, a, b);
  and g_c_ac (c_ac, a, c);
  and g_c_bc (c_bc, b, c);
  or  g_c_or (c1_out, c_ab, c_ac, c_bc);
  and g_k_ab (k_ab, a, b);
  and g_k_xc (k_xc, c, ab_x);
  or  g_k_or (c2_out, k_ab, k_xc);

  // Switch-level path: p = a^b steers both the sum and the carry selection
  (* keep = "true" *) wire sw_an, sw_p, sw_pn, ss_out, cs_out;
  not g_sw_an (sw_an, a);
  not g_sw_pn (sw_pn, sw_p);

  tg_mux2 u_mux_p (
    .d0  (a),
    .d1  (sw_an),
    .sel (b),
    .y   (sw_p)
  );

  tg_mux2 u_mux_sum (
    .d0  (sw_p),
    .d1  (sw_pn),
    .sel (c),
    .y   (ss_out)
  );

  tg_mux2 u_mux_carry (
    .d0  (a),
    .d1  (c),
    .sel (sw_p),
    .y   (cs_out)
  );

  fa_result_t res_d;
  fa_result_t res_q;
  logic       mismatch_q;

  assign res_d.sum   = {ss_out, s4_out, s3_out, s2_out, s1_out};
  assign res_d.carry = {cs_out, c2_out, c1_out};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      res_q      <= res_d;
      mismatch_q <= sum_disagree(res_q.sum) | carry_disagree(res_q.carry);
    end
  end

  assign y0       = res_q.sum[0];
  assign y0_2     = res_q.sum[1];
  assign y0_3     = res_q.sum[2];
  assign y0_4     = res_q.sum[3];
  assign y0_s     = res_q.sum[4];
  assign y1       = res_q.carry[0];
  assign y1_2     = res_q.carry[1];
  assign y1_s     = res_q.carry[2];
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_gate_switch_adder.sv
// Directed bench for gate_switch_adder: scoreboard of sum/carry per applied code.
module tb_gate_switch_adder;

  logic clk = 1'b0;
  logic rst_n;
  logic a, b, c;
  logic y0, y0_2, y0_3, y0_4, y1, y1_2, y0_s, y1_s, mismatch;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic sum;
    logic carry;
    logic [2:0] code;
  } exp_t;

  exp_t sb[$];

  gate_switch_adder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .c        (c),
    .y0       (y0),
    .y0_2     (y0_2),
    .y0_3     (y0_3),
    .y0_4     (y0_4),
    .y1       (y1),
    .y1_2     (y1_2),
    .y0_s     (y0_s),
    .y1_s     (y1_s),
    .mismatch (mismatch)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic s, input logic cy, input logic mm);
    check({tag, " y0"},       y0,       s);
    check({tag, " y0_2"},     y0_2,     s);
    check({tag, " y0_3"},     y0_3,     s);
    check({tag, " y0_4"},     y0_4,     s);
    check({tag, " y0_s"},     y0_s,     s);
    check({tag, " y1"},       y1,       cy);
    check({tag, " y1_2"},     y1_2,     cy);
    check({tag, " y1_s"},     y1_s,     cy);
    check({tag, " mismatch"}, mismatch, mm);
  endtask

  // Drive a code at the falling edge, push its expectation, check after the rising edge.
  task automatic step(input logic [2:0] code, input logic s, input logic cy, input string tag);
    exp_t e;
    @(negedge clk);
    {a, b, c} = code;
    e.sum = s; e.carry = cy; e.code = code;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: scoreboard empty, observed no entry, required one", tag);
    end else begin
      e = sb.pop_front();
      check_all($sformatf("%s abc=%03b", tag, e.code), e.sum, e.carry, 1'b0);
    end
  endtask

  function automatic logic model_sum(input logic [2:0] v);
    return v[2] ^ v[1] ^ v[0];
  endfunction

  function automatic logic model_carry(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  logic [2:0] gray_codes [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                                 3'b111, 3'b101, 3'b100, 3'b000};
  logic       gray_sums  [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  logic       gray_cars  [9] = '{0, 0, 1, 0, 1, 1, 1, 0, 0};

  initial begin
    rst_n = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      step(gray_codes[i], gray_sums[i], gray_cars[i], "gray");

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      step(v, model_sum(v), model_carry(v), "count");
    end

    // Reset in the middle of a walk clears outputs without a clock edge
    step(3'b111, 1'b1, 1'b1, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    a = 1'b0; b = 1'b1; c = 1'b1;
    rst_n = 1'b1;
    step(3'b011, 1'b0, 1'b1, "post_reset");

    // Glitch on a between edges must not reach the registers
    step(3'b000, 1'b0, 1'b0, "glitch_base");
    #1 a = 1'b1;
    #2 check_all("glitch_mid", 1'b0, 1'b0, 1'b0);
    #1 a = 1'b0;
    @(posedge clk);
    #1;
    check_all("glitch_after", 1'b0, 1'b0, 1'b0);

    // Fault on the NAND network output is flagged two edges later
    step(3'b100, 1'b1, 1'b0, "fault_base");
    force dut.s3_out = 1'b0;
    @(posedge clk);
    #1;
    check("fault y0_3", y0_3, 1'b0);
    check("fault y0", y0, 1'b1);
    check("fault mismatch_lag", mismatch, 1'b0);
    @(posedge clk);
    #1;
    check("fault mismatch", mismatch, 1'b1);
    release dut.s3_out;
    @(posedge clk);
    #1;
    check("release y0_3", y0_3, 1'b1);
    check("release mismatch_lag", mismatch, 1'b1);
    @(posedge clk);
    #1;
    check("release mismatch", mismatch, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
